pc_counter_n: RTL and testbench

//   Parametrised program-counter/incrementer register, successor to the combinational 16-bit incrementer.

---
 rtl/pc_counter_n.sv | 86 ++++++++
 tb/tb_pc_counter_n.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_counter_n.sv
// Parametrised program counter: registered count that loads, steps up/down by STEP,
// and either wraps modulo MAX_VAL+1 or saturates at 0/MAX_VAL, flagging either event.
module pc_counter_n #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] STEP    = WIDTH'(1),
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             inc,
    input  logic             dec,
    input  logic             sat_en,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             sat,
    output logic             at_zero,
    output logic             at_max
);

    // Bound arithmetic is carried in WIDTH+1 bits so q+STEP and the modulus never truncate.
    localparam logic [WIDTH:0] MAX_EXT  = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] STEP_EXT = {1'b0, STEP};
    localparam logic [WIDTH:0] MODULUS  = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

    assign up_sum = {1'b0, q} + STEP_EXT;

    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;
        if (load) begin
            if (din > MAX_VAL) begin
                q_nxt   = MAX_VAL;
                sat_nxt = 1'b1;
            end else begin
                q_nxt = din;
            end
        end else if (inc && !dec) begin
            if (up_sum > MAX_EXT) begin
                if (sat_en) begin
                    q_nxt   = MAX_VAL;
                    sat_nxt = 1'b1;
                end else begin
                    q_nxt    = WIDTH'(up_sum - MODULUS);
                    wrap_nxt = 1'b1;
                end
            end else begin
                q_nxt = WIDTH'(up_sum);
            end
        end else if (dec && !inc) begin
            if (q >= STEP) begin
                q_nxt = q - STEP;
            end else if (sat_en) begin
                q_nxt   = '0;
                sat_nxt = 1'b1;
            end else begin
                // q < STEP here, so q + MODULUS - STEP lands inside 0..MAX_VAL.
                q_nxt    = WIDTH'({1'b0, q} + MODULUS - STEP_EXT);
                wrap_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
            sat  <= sat_nxt;
        end
    end

    assign at_zero = (q == '0);
    assign at_max  = (q == MAX_VAL);

endmodule

// File: tb/tb_pc_counter_n.sv
// Scoreboard bench for pc_counter_n: a default 16-bit instance and a W4/STEP3/MAX9 instance.
module tb_pc_counter_n;

    typedef struct {
        longint q;
        bit     wrap;
        bit     sat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        reset_a = 1'b0, load_a = 1'b0, inc_a = 1'b0, dec_a = 1'b0, sat_en_a = 1'b0;
    logic [15:0] din_a = '0;
    logic [15:0] q_a;
    logic        wrap_a, sat_a, at_zero_a, at_max_a;

    logic        reset_b = 1'b0, load_b = 1'b0, inc_b = 1'b0, dec_b = 1'b0, sat_en_b = 1'b0;
    logic [3:0]  din_b = '0;
    logic [3:0]  q_b;
    logic        wrap_b, sat_b, at_zero_b, at_max_b;

    pc_counter_n u_dut_a (
        .clk(clk), .reset(reset_a), .load(load_a), .din(din_a), .inc(inc_a), .dec(dec_a),
        .sat_en(sat_en_a), .q(q_a), .wrap(wrap_a), .sat(sat_a), .at_zero(at_zero_a), .at_max(at_max_a)
    );

    pc_counter_n #(.WIDTH(4), .STEP(4'd3), .MAX_VAL(4'd9)) u_dut_b (
        .clk(clk), .reset(reset_b), .load(load_b), .din(din_b), .inc(inc_b), .dec(dec_b),
        .sat_en(sat_en_b), .q(q_b), .wrap(wrap_b), .sat(sat_b), .at_zero(at_zero_b), .at_max(at_max_b)
    );

    exp_t   exp_a[$];
    exp_t   exp_b[$];
    longint mdl_q_a = 0;
    longint mdl_q_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input longint q, input bit rst, input bit ld, input longint din,
                                   input bit up, input bit dn, input bit sat_mode,
                                   input longint step, input longint maxv);
        exp_t r;
        r.q = q; r.wrap = 0; r.sat = 0;
        if (rst) begin
            r.q = 0;
        end else if (ld) begin
            if (din > maxv) begin r.q = maxv; r.sat = 1; end
            else r.q = din;
        end else if (up && !dn) begin
            if (q + step <= maxv) r.q = q + step;
            else if (sat_mode) begin r.q = maxv; r.sat = 1; end
            else begin r.q = q + step - (maxv + 1); r.wrap = 1; end
        end else if (dn && !up) begin
            if (q >= step) r.q = q - step;
            else if (sat_mode) begin r.q = 0; r.sat = 1; end
            else begin r.q = q + (maxv + 1) - step; r.wrap = 1; end
        end
        return r;
    endfunction

    task automatic cycle_a(input bit rst, input bit ld, input logic [15:0] d,
                           input bit up, input bit dn, input bit sm);
        exp_t e;
        @(negedge clk);
        reset_a = rst; load_a = ld; din_a = d; inc_a = up; dec_a = dn; sat_en_a = sm;
        e = model(mdl_q_a, rst, ld, longint'(d), up, dn, sm, 1, 65535);
        mdl_q_a = e.q;
        exp_a.push_back(e);
        @(posedge clk);
        #1;
        if (exp_a.size() == 0) begin
            check("a_queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_a.pop_front();
            check("a_q", 32'(q_a), 32'(e.q));
            check("a_wrap", 32'(wrap_a), 32'(e.wrap));
            check("a_sat", 32'(sat_a), 32'(e.sat));
            check("a_at_zero", 32'(at_zero_a), 32'(e.q == 0));
            check("a_at_max", 32'(at_max_a), 32'(e.q == 65535));
        end
    endtask

    task automatic cycle_b(input bit rst, input bit ld, input logic [3:0] d,
                           input bit up, input bit dn, input bit sm);
        exp_t e;
        @(negedge clk);
        reset_b = rst; load_b = ld; din_b = d; inc_b = up; dec_b = dn; sat_en_b = sm;
        e = model(mdl_q_b, rst, ld, longint'(d), up, dn, sm, 3, 9);
        mdl_q_b = e.q;
        exp_b.push_back(e);
        @(posedge clk);
        #1;
        if (exp_b.size() == 0) begin
            check("b_queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_b.pop_front();
            check("b_q", 32'(q_b), 32'(e.q));
            check("b_wrap", 32'(wrap_b), 32'(e.wrap));
            check("b_sat", 32'(sat_b), 32'(e.sat));
            check("b_at_zero", 32'(at_zero_b), 32'(e.q == 0));
            check("b_at_max", 32'(at_max_b), 32'(e.q == 9));
        end
    endtask

    initial begin
        // Directed sequence on the default instance, with literal spot checks.
        cycle_a(1, 0, 16'h0000, 0, 0, 0);
        check("a_reset_q", 32'(q_a), 32'h0000);
        check("a_reset_zero", 32'(at_zero_a), 32'd1);
        repeat (3) cycle_a(0, 0, 16'h0000, 1, 0, 0);
        check("a_inc3", 32'(q_a), 32'h0003);
        cycle_a(0, 1, 16'h0FFF, 0, 0, 0);
        cycle_a(0, 0, 16'h0000, 1, 0, 0);
        check("a_carry", 32'(q_a), 32'h1000);
        cycle_a(0, 1, 16'hFFFE, 0, 0, 0);
        cycle_a(0, 0, 16'h0000, 1, 0, 0);
        check("a_max", 32'(at_max_a), 32'd1);
        cycle_a(0, 0, 16'h0000, 1, 0, 0);
        check("a_wrap_q", 32'(q_a), 32'h0000);
        check("a_wrap_pulse", 32'(wrap_a), 32'd1);
        cycle_a(0, 0, 16'h0000, 0, 0, 0);
        check("a_wrap_clear", 32'(wrap_a), 32'd0);
        cycle_a(0, 1, 16'hFFFF, 0, 0, 1);
        cycle_a(0, 0, 16'h0000, 1, 0, 1);
        check("a_sat_hi_q", 32'(q_a), 32'hFFFF);
        check("a_sat_hi", 32'(sat_a), 32'd1);
        cycle_a(0, 1, 16'h0000, 0, 0, 1);
        cycle_a(0, 0, 16'h0000, 0, 1, 1);
        check("a_sat_lo_q", 32'(q_a), 32'h0000);
        check("a_sat_lo", 32'(sat_a), 32'd1);
        cycle_a(0, 0, 16'h0000, 1, 1, 1);
        check("a_both_sat", 32'(sat_a), 32'd0);
        cycle_a(0, 1, 16'h1234, 0, 0, 0);
        cycle_a(1, 0, 16'h0000, 1, 0, 0);
        check("a_midreset", 32'(q_a), 32'h0000);
        cycle_a(0, 1, 16'hABCD, 1, 0, 0);
        check("a_load_wins", 32'(q_a), 32'hABCD);
        cycle_a(0, 1, 16'h0001, 0, 0, 0);
        cycle_a(0, 0, 16'h0000, 0, 1, 0);
        cycle_a(0, 0, 16'h0000, 0, 1, 0);
        check("a_dec_wrap", 32'(q_a), 32'hFFFF);
        for (int i = 0; i < 300; i++)
            cycle_a(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                    16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        // Non-power-of-two modulus with a multi-unit step.
        cycle_b(1, 0, 4'h0, 0, 0, 0);
        cycle_b(0, 1, 4'h8, 0, 0, 0);
        cycle_b(0, 0, 4'h0, 1, 0, 0);
        check("b_inc_wrap_q", 32'(q_b), 32'd1);
        check("b_inc_wrap", 32'(wrap_b), 32'd1);
        cycle_b(0, 0, 4'h0, 0, 1, 0);
        check("b_dec_wrap_q", 32'(q_b), 32'd8);
        check("b_dec_wrap", 32'(wrap_b), 32'd1);
        cycle_b(0, 1, 4'hF, 0, 0, 0);
        check("b_load_clip_q", 32'(q_b), 32'd9);
        check("b_load_clip", 32'(sat_b), 32'd1);
        cycle_b(0, 0, 4'h0, 1, 0, 1);
        cycle_b(0, 1, 4'h7, 0, 0, 1);
        cycle_b(0, 0, 4'h0, 1, 0, 1);
        check("b_sat_up", 32'(q_b), 32'd9);
        cycle_b(0, 1, 4'h2, 0, 0, 1);
        cycle_b(0, 0, 4'h0, 0, 1, 1);
        check("b_sat_dn", 32'(q_b), 32'd0);
        for (int i = 0; i < 300; i++)
            cycle_b(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                    4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
